// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 3-digit BCD (hundreds 0..3, tens, ones) to 8-bit binary via reverse double-dabble, one shift per clock
//   clk, reset (sync, active-high); in_valid/in_ready + in_hundreds/in_tens/in_ones digit input;
//   out_valid/out_ready + out_value, out_ovf (value > 255), out_err (invalid digit) result output
module bcd_to_bin #(
  parameter bit CHECK_DIGITS = 1'b1,
  parameter bit SATURATE     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_hundreds,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_ones,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_value,
  output logic       out_ovf,
  output logic       out_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [18:0] scr, sh, nxt;
  logic [3:0]  cnt;
  logic        bad;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign bad = CHECK_DIGITS && (in_tens > 4'd9 || in_ones > 4'd9);
  // a digit field that is >= 8 after the shift right held an odd upper digit; subtracting 3 undoes the carried-in 5
  always_comb begin
    sh  = scr >> 1;
    nxt = {sh[18:17], sh[16] ? sh[16:13] - 4'd3 : sh[16:13],
           sh[12] ? sh[12:9] - 4'd3 : sh[12:9], sh[8:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scr       <= '0;
      cnt       <= '0;
      out_value <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (bad) begin
            state     <= DONE;
            out_value <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b1;
          end else begin
            state <= SHIFT;
            scr   <= {in_hundreds, in_tens, in_ones, 9'd0};
            cnt   <= '0;
          end
        end
        SHIFT: begin
          scr <= nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) begin
            state     <= DONE;
            out_ovf   <= nxt[8];
            out_value <= (nxt[8] && SATURATE) ? 8'hFF : nxt[7:0];
            out_err   <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
